// File: rtl/uart_program_loader_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_loader_pkg
// Description : Shared constants, loader state type and sizing helpers for the
//               UART program loader (frame header byte, bit-period divider,
//               inter-byte timeout length, counter widths).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package uart_loader_pkg;

    localparam logic [7:0] LOADER_HDR = 8'hA5;

    // CHK is only reached when UART_PROGRAM_LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        WAIT_HDR = 3'd0,
        GET_CNT  = 3'd1,
        GET_WORD = 3'd2,
        CHK      = 3'd3,
        DONE     = 3'd4
    } loader_state_t;

    // Clock cycles per UART bit, rounded to the nearest integer.
    function automatic int unsigned bit_period(input int unsigned clk_mhz,
                                               input int unsigned baud_rate);
        return (clk_mhz * 1_000_000 + baud_rate / 2) / baud_rate;
    endfunction

    // Longest tolerated byte-to-byte gap inside a frame, in clock cycles.
    function automatic int unsigned timeout_cycles(input int unsigned clk_mhz,
                                                   input int unsigned timeout_ms);
        return clk_mhz * 1000 * timeout_ms;
    endfunction

    // Bits needed for a counter that must hold the value max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_program_loader_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_program_loader_if
// Description : Bundles the serial input, instruction-store write port and
//               status outputs of the program loader.
//   uart_rx   : serial input, idle high
//   prog_we   : one-cycle write strobe to the instruction store
//   prog_addr : word-aligned byte address of the write
//   prog_data : word to write
//   cpu_rst   : 1 = hold the CPU in reset
//   loading   : loader is inside a frame (count / data phase)
//   done      : last load completed successfully
//   error     : last load failed (sticky until the next header byte)
//   word_cnt  : words written by the current or last load
//   Modports  : master = loader side, slave = environment side
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface uart_program_loader_if;
    logic        uart_rx;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        cpu_rst;
    logic        loading;
    logic        done;
    logic        error;
    logic [7:0]  word_cnt;

    modport master (
        input  uart_rx,
        output prog_we, prog_addr, prog_data, cpu_rst, loading, done, error, word_cnt
    );

    modport slave (
        output uart_rx,
        input  prog_we, prog_addr, prog_data, cpu_rst, loading, done, error, word_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_program_loader_uart_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_rx
// Description : 8N1 UART byte receiver with two-flop input synchronizer,
//               mid-bit start confirmation and mid-bit data sampling.
//   clk, rst  : system clock, asynchronous active-high reset
//   rx        : asynchronous serial input, idle high
//   rx_valid  : one-cycle pulse, rx_byte valid (stop bit was 1)
//   rx_byte   : received byte, LSB first on the line
//   frame_err : one-cycle pulse when the stop bit sampled 0
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLK_MHZ   = 50,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned c_div  = bit_period(CLK_MHZ, BAUD_RATE);
    localparam int unsigned c_half = c_div / 2;
    localparam int unsigned c_cw   = cnt_width(c_div);
    localparam logic [c_cw-1:0] c_div_last  = c_cw'(c_div - 1);
    localparam logic [c_cw-1:0] c_half_last = c_cw'(c_half - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t       r_state;
    logic [1:0]      r_sync;
    logic [c_cw-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_rx;

    assign w_rx = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_byte   <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) r_state <= RX_START;
                end
                RX_START: begin
                    // Line must still be low half a bit after the falling edge,
                    // otherwise it was a glitch.
                    if (r_cnt == c_half_last) begin
                        r_cnt   <= '0;
                        r_bit   <= 3'd0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                        else               r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (w_rx) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= r_shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_program_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_program_loader
// Description : Receives a framed program image over UART
//               (A5, N, N*4 little-endian data bytes) and writes it word by
//               word into the instruction store, holding the CPU in reset
//               until a complete valid image has been written.
//   clk, rst  : system clock, asynchronous active-high reset
//   bus       : uart_program_loader_if.master (serial in, write port, status)
// Optional    : UART_PROGRAM_LOADER_CHECKSUM_EN - a trailing XOR checksum byte
//               over all data bytes must match before the load is accepted.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLK_MHZ    = 50,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned TIMEOUT_MS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_program_loader_if.master bus
);

    localparam int unsigned c_tmo = timeout_cycles(CLK_MHZ, TIMEOUT_MS);
    localparam int unsigned c_tw  = cnt_width(c_tmo);
    localparam logic [c_tw-1:0] c_tmo_lim = c_tw'(c_tmo);

    logic            w_rx_valid;
    logic [7:0]      w_rx_byte;
    logic            w_frame_err;

    loader_state_t   r_state;
    logic [7:0]      r_count;
    logic [7:0]      r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [23:0]     r_word;      // first three bytes of the word in flight
    logic [c_tw-1:0] r_tmo;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic            r_prog_we;
    logic [31:0]     r_prog_addr;
    logic [31:0]     r_prog_data;
    logic            r_cpu_rst;
    logic            r_done;
    logic            r_error;
    logic [7:0]      r_word_cnt;

    logic            w_in_frame;
    logic            w_tmo_hit;
    logic            w_hdr;
    logic            w_last_word;
    logic            w_overflow;
    logic            w_img_too_big;

    uart_rx #(
        .CLK_MHZ   (CLK_MHZ),
        .BAUD_RATE (BAUD_RATE)
    ) u_uart_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (bus.uart_rx),
        .rx_valid  (w_rx_valid),
        .rx_byte   (w_rx_byte),
        .frame_err (w_frame_err)
    );

    assign w_in_frame    = (r_state == GET_CNT) || (r_state == GET_WORD) || (r_state == CHK);
    assign w_tmo_hit     = (r_tmo == c_tmo_lim);
    assign w_hdr         = w_rx_valid && (w_rx_byte == LOADER_HDR);
    assign w_last_word   = (r_word_idx == (r_count - 8'd1));
    assign w_overflow    = (32'(r_word_idx) >= IMEM_WORDS);
    // Overflow grows monotonically with the word index, so the image is
    // rejected exactly when its word count exceeds the store depth.
    assign w_img_too_big = (32'(r_count) > IMEM_WORDS);

    assign bus.prog_we   = r_prog_we;
    assign bus.prog_addr = r_prog_addr;
    assign bus.prog_data = r_prog_data;
    assign bus.cpu_rst   = r_cpu_rst;
    assign bus.loading   = (r_state == GET_CNT) || (r_state == GET_WORD);
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.word_cnt  = r_word_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_HDR;
            r_count     <= 8'd0;
            r_word_idx  <= 8'd0;
            r_byte_idx  <= 2'd0;
            r_word      <= 24'd0;
            r_tmo       <= '0;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
            r_prog_we   <= 1'b0;
            r_prog_addr <= 32'd0;
            r_prog_data <= 32'd0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_word_cnt  <= 8'd0;
        end else begin
            r_prog_we <= 1'b0;

            // Gap counter restarts on every byte; a byte arriving together
            // with expiry wins because rx_valid is checked first below.
            if (!w_in_frame || w_rx_valid) r_tmo <= '0;
            else if (!w_tmo_hit)           r_tmo <= r_tmo + c_tw'(1);

            case (r_state)
                WAIT_HDR, DONE: begin
                    if (w_hdr) begin
                        r_state    <= GET_CNT;
                        r_error    <= 1'b0;
                        r_done     <= 1'b0;
                        r_word_cnt <= 8'd0;
                        r_cpu_rst  <= 1'b1;
                    end
                end
                GET_CNT: begin
                    if (w_rx_valid) begin
                        if (w_rx_byte == 8'd0) begin
                            r_error <= 1'b1;
                            r_state <= WAIT_HDR;
                        end else begin
                            r_count    <= w_rx_byte;
                            r_word_idx <= 8'd0;
                            r_byte_idx <= 2'd0;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
                            r_csum     <= 8'd0;
`endif
                            r_state    <= GET_WORD;
                        end
                    end else if (w_frame_err || w_tmo_hit) begin
                        r_error <= 1'b1;
                        r_state <= WAIT_HDR;
                    end
                end
                GET_WORD: begin
                    if (w_rx_valid) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_word     <= {w_rx_byte, r_word[23:8]};
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ w_rx_byte;
`endif
                        if (r_byte_idx == 2'd3) begin
                            if (!w_overflow) begin
                                r_prog_we   <= 1'b1;
                                r_prog_addr <= {22'd0, r_word_idx, 2'b00};
                                r_prog_data <= {w_rx_byte, r_word};
                                r_word_cnt  <= r_word_cnt + 8'd1;
                            end
                            r_word_idx <= r_word_idx + 8'd1;
                            if (w_last_word) begin
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
                                r_state <= CHK;
`else
                                if (w_img_too_big) begin
                                    r_error <= 1'b1;
                                    r_state <= WAIT_HDR;
                                end else begin
                                    r_done    <= 1'b1;
                                    r_cpu_rst <= 1'b0;
                                    r_state   <= DONE;
                                end
`endif
                            end
                        end
                    end else if (w_frame_err || w_tmo_hit) begin
                        r_error <= 1'b1;
                        r_state <= WAIT_HDR;
                    end
                end
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (w_rx_valid) begin
                        if ((w_rx_byte == r_csum) && !w_img_too_big) begin
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                            r_state   <= DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= WAIT_HDR;
                        end
                    end else if (w_frame_err || w_tmo_hit) begin
                        r_error <= 1'b1;
                        r_state <= WAIT_HDR;
                    end
                end
`endif
                default: r_state <= WAIT_HDR;
            endcase
        end
    end

endmodule
`default_nettype wire
